period_meter: RTL and testbench

- Parametrised period measurement block: counts iClk cycles between qualifying edges of an asynchronous input.
- Averages over 2^AVG_LOG2 consecutive periods and saturates on slow or absent input, raising a timeout.
- Publishes a registered period word with a one-cycle valid strobe.
- Sits between the raw signal pin and the frequency/BCD display path of the frequency counter.

---
 rtl/period_meter_pkg.sv | 22 ++
 rtl/period_meter_if.sv | 32 +++
 rtl/period_meter_edge_sync.sv | 44 ++++
 rtl/period_meter.sv | 153 +++++++++++++++
 tb/tb_period_meter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding,
// qualifying-edge selectors and the accumulator width rule.
package period_meter_pkg;

    // FSM encoding; the fourth code is unreachable and decodes to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // Qualifying edge selectors for EDGE_MODE.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;

    // The accumulator holds up to 2^avgLog2 samples of cntW bits each,
    // so avgLog2 extra bits are enough to never overflow.
    function automatic int accWidth(input int cntW, input int avgLog2);
        return cntW + avgLog2;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Measurement bundle between the signal pin side and the display path.
// master: drives iSignal/iEnable, observes results. slave: the meter.
interface period_meter_if #(
    parameter int CNT_W = 14
);

    logic             iSignal;  // raw asynchronous input
    logic             iEnable;  // low forces the meter idle
    logic [CNT_W-1:0] oPeriod;  // averaged period in clocks
    logic             oValid;   // one-cycle strobe on update
    logic             oTimeout; // last result was a saturation
    logic             oBusy;    // meter is arming or measuring

    modport master (
        output iSignal,
        output iEnable,
        input  oPeriod,
        input  oValid,
        input  oTimeout,
        input  oBusy
    );

    modport slave (
        input  iSignal,
        input  iEnable,
        output oPeriod,
        output oValid,
        output oTimeout,
        output oBusy
    );

endinterface

// File: rtl/period_meter_edge_sync.sv
// Synchroniser and edge detector for the measured signal.
// Ports: iClk, iRst (sync, active-high), iSignal (async), oEdge (pulse).
module period_meter_edge_sync
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSignal,
    output logic oEdge
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   histQ;
    logic                   edgeNow;
    logic                   lastSample;

    assign lastSample = syncQ[SYNC_STAGES-1];

    generate
        if (EDGE_MODE == EDGE_FALL) begin : gFall
            assign edgeNow = histQ & ~lastSample;
        end else begin : gRise
            assign edgeNow = ~histQ & lastSample;
        end
    endgenerate

    // The pulse is registered so that a pin change shows up on oEdge
    // exactly SYNC_STAGES+1 cycles later, independent of EDGE_MODE.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncQ <= '0;
            histQ <= 1'b0;
            oEdge <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], iSignal};
            histQ <= lastSample;
            oEdge <= edgeNow;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Period meter: counts iClk cycles between qualifying edges, averages
// 2^AVG_LOG2 periods and saturates at SAT_VAL with a timeout flag.
// Ports: iClk, iRst (sync, active-high), bus (period_meter_if.slave).
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 14,
    parameter int SAT_VAL     = 10000,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic          iClk,
    input  logic          iRst,
    period_meter_if.slave bus
);

    localparam int ACC_W = accWidth(CNT_W, AVG_LOG2);
    localparam int WIN_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] SAT      = CNT_W'(SAT_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

    state_t stateQ;
    state_t stateD;

    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntD;
    logic [ACC_W-1:0] accQ;
    logic [ACC_W-1:0] accD;
    logic [WIN_W-1:0] winQ;
    logic [WIN_W-1:0] winD;
    logic [CNT_W-1:0] periodQ;
    logic [CNT_W-1:0] periodD;
    logic             validQ;
    logic             validD;
    logic             timeoutQ;
    logic             timeoutD;

    logic             edgePulse;
    logic             satHit;
    logic [ACC_W-1:0] accSum;

    period_meter_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) uEdgeSync (
        .iClk    (iClk),
        .iRst    (iRst),
        .iSignal (bus.iSignal),
        .oEdge   (edgePulse)
    );

    assign satHit = (cntQ == SAT);
    assign accSum = accQ + ACC_W'(cntQ);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accD     = accQ;
        winD     = winQ;
        periodD  = periodQ;
        validD   = 1'b0;
        timeoutD = timeoutQ;

        if (!bus.iEnable) begin
            // Dropping enable abandons any partial window silently.
            stateD = ST_IDLE;
            cntD   = '0;
            accD   = '0;
            winD   = '0;
        end else begin
            unique case (stateQ)
                ST_IDLE: begin
                    stateD = ST_ARM;
                    cntD   = '0;
                    accD   = '0;
                    winD   = '0;
                end
                ST_ARM, ST_MEASURE: begin
                    if (satHit) begin
                        // Saturation beats a coincident edge.
                        stateD   = ST_ARM;
                        cntD     = '0;
                        accD     = '0;
                        winD     = '0;
                        periodD  = SAT;
                        validD   = 1'b1;
                        timeoutD = 1'b1;
                    end else if (edgePulse) begin
                        // The arming edge only starts timing.
                        stateD = ST_MEASURE;
                        cntD   = CNT_ONE;
                        if (stateQ == ST_MEASURE) begin
                            if (winQ == WIN_LAST) begin
                                periodD  = CNT_W'(accSum >> AVG_LOG2);
                                validD   = 1'b1;
                                timeoutD = 1'b0;
                                accD     = '0;
                                winD     = '0;
                            end else begin
                                accD = accSum;
                                winD = winQ + WIN_ONE;
                            end
                        end
                    end else begin
                        cntD = cntQ + CNT_ONE;
                    end
                end
                default: begin
                    stateD = ST_IDLE;
                    cntD   = '0;
                    accD   = '0;
                    winD   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cntQ     <= '0;
            accQ     <= '0;
            winQ     <= '0;
            periodQ  <= '0;
            validQ   <= 1'b0;
            timeoutQ <= 1'b0;
        end else begin
            cntQ     <= cntD;
            accQ     <= accD;
            winQ     <= winD;
            periodQ  <= periodD;
            validQ   <= validD;
            timeoutQ <= timeoutD;
        end
    end

    assign bus.oPeriod  = periodQ;
    assign bus.oValid   = validQ;
    assign bus.oTimeout = timeoutQ;
    assign bus.oBusy    = (stateQ == ST_ARM) || (stateQ == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed and randomized checks of period_meter against an
// edge-timestamp averaging model; one rising and one falling instance.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int CW  = 14;
    localparam int SAT = 10000;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   cycN = 0;
    int   total = 0;
    int   bad = 0;

    period_meter_if #(.CNT_W(CW)) bus ();
    period_meter_if #(.CNT_W(CW)) busF ();

    period_meter #(
        .CNT_W(CW), .SAT_VAL(SAT), .SYNC_STAGES(2),
        .AVG_LOG2(2), .EDGE_MODE(EDGE_RISE)
    ) dut (
        .iClk(iClk), .iRst(iRst), .bus(bus)
    );

    period_meter #(
        .CNT_W(CW), .SAT_VAL(SAT), .SYNC_STAGES(2),
        .AVG_LOG2(2), .EDGE_MODE(EDGE_FALL)
    ) dutF (
        .iClk(iClk), .iRst(iRst), .bus(busF)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cycN <= cycN + 1;

    int   gotP[$], gotT[$], gotC[$];
    int   fP[$], fT[$], fC[$];
    int   edges[$], fEdges[$];
    int   expv[$];
    logic prevV = 1'b0;
    logic prevVF = 1'b0;
    int   dbl = 0;

    always @(negedge iClk) begin
        if (bus.oValid) begin
            gotP.push_back(int'(bus.oPeriod));
            gotT.push_back(int'(bus.oTimeout));
            gotC.push_back(cycN);
        end
        if (busF.oValid) begin
            fP.push_back(int'(busF.oPeriod));
            fT.push_back(int'(busF.oTimeout));
            fC.push_back(cycN);
        end
        if ((bus.oValid && prevV) || (busF.oValid && prevVF))
            dbl <= dbl + 1;
        prevV  <= bus.oValid;
        prevVF <= busF.oValid;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Reference: successive edge timestamps give periods; every four
    // consecutive periods produce one truncated mean.
    function automatic void modelAvg(input int e[$], output int r[$]);
        int acc = 0;
        int k = 0;
        r.delete();
        for (int i = 1; i < e.size(); i++) begin
            acc += e[i] - e[i-1];
            k++;
            if (k == 4) begin
                r.push_back(acc / 4);
                acc = 0;
                k = 0;
            end
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic wave(input int p);
        edges.push_back(cycN);
        bus.iSignal = 1'b1;
        cyc(p / 2);
        bus.iSignal = 1'b0;
        cyc(p - p / 2);
    endtask

    task automatic wave25(input int p);
        busF.iSignal = 1'b1;
        cyc(p / 4);
        fEdges.push_back(cycN);
        busF.iSignal = 1'b0;
        cyc(p - p / 4);
    endtask

    task automatic clearQ();
        gotP.delete();
        gotT.delete();
        gotC.delete();
        edges.delete();
    endtask

    task automatic restart();
        bus.iEnable = 1'b0;
        cyc(3);
        bus.iEnable = 1'b1;
        cyc(3);
        clearQ();
    endtask

    task automatic waitRes(input string tag, input int n, input int maxC);
        int k = 0;
        while (gotP.size() < n && k < maxC) begin
            @(negedge iClk);
            k++;
        end
        cyc(2);
        check({tag, "_count"}, gotP.size(), n);
    endtask

    task automatic checkRes(input string tag, input int e[$]);
        for (int i = 0; i < e.size(); i++) begin
            check({tag, "_period"}, at(gotP, i), e[i]);
            check({tag, "_tmo"}, at(gotT, i), 0);
        end
    endtask

    initial begin
        int k;
        bus.iSignal  = 1'b0;
        bus.iEnable  = 1'b0;
        busF.iSignal = 1'b0;
        busF.iEnable = 1'b0;
        iRst = 1'b1;
        cyc(3);
        check("rst_period", int'(bus.oPeriod), 0);
        check("rst_valid", int'(bus.oValid), 0);
        check("rst_tmo", int'(bus.oTimeout), 0);
        check("rst_busy", int'(bus.oBusy), 0);
        iRst = 1'b0;
        cyc(2);
        check("idle_busy", int'(bus.oBusy), 0);

        // Square wave, period 8: two windows.
        bus.iEnable = 1'b1;
        cyc(3);
        check("arm_busy", int'(bus.oBusy), 1);
        clearQ();
        repeat (9) wave(8);
        waitRes("sq8", 2, 200);
        modelAvg(edges, expv);
        checkRes("sq8", expv);
        check("sq8_const", at(gotP, 0), 8);
        check("sq8_lag", at(gotC, 0), at(edges, 4) + 4);
        check("sq8_gap", at(gotC, 1) - at(gotC, 0), 32);

        // Truncating average of 7,8,9,10.
        restart();
        foreach (expv[i]) expv.delete(i);
        wave(7); wave(8); wave(9); wave(10); wave(8);
        waitRes("trunc", 1, 200);
        modelAvg(edges, expv);
        checkRes("trunc", expv);
        check("trunc_const", at(gotP, 0), 8);

        // Random periods, three windows.
        restart();
        repeat (13) wave(int'($urandom_range(4, 60)));
        waitRes("rand", 3, 200);
        modelAvg(edges, expv);
        checkRes("rand", expv);

        // Constant input: saturation, then recovery.
        restart();
        waitRes("sat", 1, SAT + 100);
        check("sat_period", at(gotP, 0), SAT);
        check("sat_tmo", at(gotT, 0), 1);
        check("sat_busy", int'(bus.oBusy), 1);
        check("sat_hold", int'(bus.oTimeout), 1);
        clearQ();
        repeat (5) wave(8);
        waitRes("resume", 1, 200);
        modelAvg(edges, expv);
        checkRes("resume", expv);
        check("resume_flag", int'(bus.oTimeout), 0);

        // Enable dropped mid-window.
        restart();
        repeat (3) wave(20);
        bus.iEnable = 1'b0;
        cyc(5);
        check("drop_count", gotP.size(), 0);
        check("drop_period", int'(bus.oPeriod), 8);
        check("drop_tmo", int'(bus.oTimeout), 0);
        check("drop_busy", int'(bus.oBusy), 0);
        bus.iEnable = 1'b1;
        cyc(3);
        clearQ();
        wave(10); wave(10); wave(11); wave(12); wave(9);
        waitRes("rearm", 1, 200);
        modelAvg(edges, expv);
        checkRes("rearm", expv);
        check("rearm_const", at(gotP, 0), 10);

        // Reset pulse in the middle of a window.
        clearQ();
        repeat (2) wave(8);
        iRst = 1'b1;
        cyc(1);
        check("mrst_period", int'(bus.oPeriod), 0);
        check("mrst_valid", int'(bus.oValid), 0);
        check("mrst_tmo", int'(bus.oTimeout), 0);
        check("mrst_busy", int'(bus.oBusy), 0);
        iRst = 1'b0;
        cyc(4);
        check("mrst_count", gotP.size(), 0);
        check("mrst_rearm", int'(bus.oBusy), 1);

        // Period 9999 is a sample; an edge landing on saturation is not.
        restart();
        wave(9999);
        wave(10000);
        repeat (6) wave(8);
        waitRes("coin", 2, 200);
        check("coin_p0", at(gotP, 0), SAT);
        check("coin_t0", at(gotT, 0), 1);
        check("coin_p1", at(gotP, 1), 8);
        check("coin_t1", at(gotT, 1), 0);

        // Falling-edge instance, 25% duty, period 12.
        busF.iEnable = 1'b1;
        cyc(3);
        fP.delete();
        fT.delete();
        fC.delete();
        fEdges.delete();
        repeat (5) wave25(12);
        k = 0;
        while (fP.size() < 1 && k < 100) begin
            @(negedge iClk);
            k++;
        end
        cyc(2);
        check("fall_count", fP.size(), 1);
        check("fall_period", at(fP, 0), 12);
        check("fall_tmo", at(fT, 0), 0);
        check("fall_lag", at(fC, 0), at(fEdges, 4) + 4);

        check("no_double_valid", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
